regfile_writeback: RTL

Write-side front end of the register file. Arbitrates register writebacks from the single-cycle ALU path and the multi-cycle load/store path onto the register file's single write port. Keeps a per-register busy scoreboard for outstanding loads so decode can stall. Forwards the in-flight write to the two read ports so readers never see stale data.

---
 rtl/rv32_pkg.sv | 10 +
 rtl/reg_scoreboard.sv | 39 +++
 rtl/regfile_writeback.sv | 100 ++++++++++
 3 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32 definitions for the register-file write-side logic.
package rv32_pkg;
    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic {
        WB_ALU = 1'b0,
        WB_LSU = 1'b1
    } wb_src_e;
endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy bits for outstanding loads, with two combinational lookups.
module reg_scoreboard #(
    parameter int NREGS = 32,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          arstn,
    input  logic          set_en,
    input  logic [AW-1:0] set_addr,
    input  logic          clr_en,
    input  logic [AW-1:0] clr_addr,
    input  logic [AW-1:0] read_addr1,
    input  logic [AW-1:0] read_addr2,
    output logic          busy1,
    output logic          busy2
);
    import rv32_pkg::*;

    logic [NREGS-1:0] busy;

    // A load issued on the same edge its predecessor returns keeps the register busy.
    always_ff @(posedge clk) begin
        if (!arstn) begin
            busy <= '0;
        end else begin
            busy[0] <= 1'b0;
            for (int i = 1; i < NREGS; i++) begin
                if (set_en && (set_addr == AW'(i))) begin
                    busy[i] <= 1'b1;
                end else if (clr_en && (clr_addr == AW'(i))) begin
                    busy[i] <= 1'b0;
                end
            end
        end
    end

    assign busy1 = busy[read_addr1];
    assign busy2 = busy[read_addr2];
endmodule

// File: rtl/regfile_writeback.sv
// Arbitrates ALU and LSU writebacks onto the single register-file write port,
// registers the write, and forwards it to the two read ports.
module regfile_writeback #(
    parameter int XLEN  = rv32_pkg::XLEN,
    parameter int NREGS = 32,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            arstn,
    input  logic            aluValid,
    output logic            aluReady,
    input  logic [AW-1:0]   aluAddr,
    input  logic [XLEN-1:0] aluData,
    input  logic            lsuValid,
    output logic            lsuReady,
    input  logic [AW-1:0]   lsuAddr,
    input  logic [XLEN-1:0] lsuData,
    input  logic            issueEn,
    input  logic [AW-1:0]   issueAddr,
    input  logic [AW-1:0]   readAddr1,
    input  logic [AW-1:0]   readAddr2,
    output logic            busy1,
    output logic            busy2,
    output logic            fwdHit1,
    output logic            fwdHit2,
    output logic [XLEN-1:0] fwdData,
    output logic            writeEn,
    output logic [AW-1:0]   writeAddr,
    output logic [XLEN-1:0] writeData
);
    import rv32_pkg::*;

    wb_src_e         last_grant;
    logic            alu_fire;
    logic            lsu_fire;
    logic            contention;
    logic            fire;
    logic [AW-1:0]   sel_addr;
    logic [XLEN-1:0] sel_data;

    // An idle source may see ready=1; it only matters when its valid is high.
    always_comb begin
        aluReady = !lsuValid || (last_grant == WB_LSU);
        lsuReady = !aluValid || (last_grant == WB_ALU);
    end

    always_comb begin
        alu_fire   = aluValid && aluReady;
        lsu_fire   = lsuValid && lsuReady;
        contention = aluValid && lsuValid;
        fire       = alu_fire || lsu_fire;
        sel_addr   = alu_fire ? aluAddr : lsuAddr;
        sel_data   = alu_fire ? aluData : lsuData;
    end

    always_ff @(posedge clk) begin
        if (!arstn) begin
            last_grant <= WB_LSU;
        end else if (contention) begin
            last_grant <= alu_fire ? WB_ALU : WB_LSU;
        end
    end

    // x0 writes complete the handshake but never reach the register file.
    always_ff @(posedge clk) begin
        if (!arstn) begin
            writeEn   <= 1'b0;
            writeAddr <= '0;
            writeData <= '0;
        end else begin
            writeEn <= fire && (sel_addr != '0);
            if (fire) begin
                writeAddr <= sel_addr;
                writeData <= sel_data;
            end
        end
    end

    reg_scoreboard #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_scoreboard (
        .clk        (clk),
        .arstn      (arstn),
        .set_en     (issueEn),
        .set_addr   (issueAddr),
        .clr_en     (lsu_fire),
        .clr_addr   (lsuAddr),
        .read_addr1 (readAddr1),
        .read_addr2 (readAddr2),
        .busy1      (busy1),
        .busy2      (busy2)
    );

    always_comb begin
        fwdData = writeData;
        fwdHit1 = writeEn && (writeAddr == readAddr1) && (writeAddr != '0);
        fwdHit2 = writeEn && (writeAddr == readAddr2) && (writeAddr != '0);
    end
endmodule
